lsu_mem_master: RTL and testbench

- Initiator-side load/store unit between the CPU datapath and the word-organised data RAM.
- Takes one byte-addressed load or store per transaction from the CPU and issues word-granular read/write requests over a req/ack memory handshake.
- Sub-word stores are done as read-modify-write. Load results are lane-extracted and sign- or zero-extended.
- Returns one response (data, destination register, error) per accepted request.

---
 rtl/lsu_pkg.sv | 34 +++
 rtl/lsu_lane_align.sv | 56 +++++
 rtl/lsu_mem_master.sv | 201 ++++++++++++++++++++
 tb/tb_lsu_mem_master.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : lsu_pkg
// Brief   : Shared state encoding, RV32I width codes and defaults for the
//           lsu_mem_master load/store unit.
// Revision: 1.0 - initial release
// ============================================================================
package lsu_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD    = 3'd1,
        S_MERGE = 3'd2,
        S_WR    = 3'd3,
        S_RESP  = 3'd4
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int TIMEOUT_CYC_DEFAULT = 16;

    function automatic logic f3_valid(input logic is_store, input logic [2:0] f3);
        if (is_store)
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_lane_align.sv
`default_nettype none
// ============================================================================
// Module  : lsu_lane_align
// Brief   : Combinational lane extract + sign/zero extend for loads and
//           byte/halfword lane merge for read-modify-write stores.
// Revision: 1.0 - initial release
// ============================================================================
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  byte_off,
    input  logic [31:0] load_word,
    output logic [31:0] load_data,
    input  logic [31:0] old_word,
    input  logic [15:0] store_data,
    output logic [31:0] merged_word
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_bmask;
    logic [31:0] w_bdata;
    logic [31:0] w_hmask;
    logic [31:0] w_hdata;

    assign w_byte  = load_word[{byte_off, 3'b000} +: 8];
    assign w_half  = load_word[{byte_off[1], 4'b0000} +: 16];

    assign w_bmask = 32'h0000_00FF << {byte_off, 3'b000};
    assign w_bdata = {24'h00_0000, store_data[7:0]} << {byte_off, 3'b000};
    assign w_hmask = 32'h0000_FFFF << {byte_off[1], 4'b0000};
    assign w_hdata = {16'h0000, store_data} << {byte_off[1], 4'b0000};

    always_comb begin
        load_data = load_word;
        case (funct3)
            F3_B:    load_data = {{24{w_byte[7]}}, w_byte};
            F3_H:    load_data = {{16{w_half[15]}}, w_half};
            F3_BU:   load_data = {24'h00_0000, w_byte};
            F3_HU:   load_data = {16'h0000, w_half};
            default: load_data = load_word;
        endcase
    end

    always_comb begin
        merged_word = old_word;
        case (funct3)
            F3_B:    merged_word = (old_word & ~w_bmask) | w_bdata;
            F3_H:    merged_word = (old_word & ~w_hmask) | w_hdata;
            default: merged_word = old_word;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu_mem_master.sv
`default_nettype none
// ============================================================================
// Module  : lsu_mem_master
// Brief   : Byte-addressed load/store unit issuing word read/write requests
//           over a req/ack port; sub-word stores use read-modify-write.
//           Optional macro LSU_MISALIGN_TRAP_EN: trap misaligned H/W accesses
//           instead of aligning them down.
// Revision: 1.0 - initial release
// ============================================================================
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter int MEM_AW      = 8,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [4:0]        req_rd,
    output logic              rsp_valid,
    output logic [31:0]       rsp_data,
    output logic [4:0]        rsp_rd,
    output logic              rsp_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
);

    localparam logic [7:0] c_tmo_last = 8'(TIMEOUT_CYC - 1);

    lsu_state_t        r_state;
    lsu_state_t        w_state_next;

    logic              r_store;
    logic [2:0]        r_funct3;
    logic [MEM_AW+1:0] r_addr;
    logic [4:0]        r_rd;
    logic [15:0]       r_wdata;
    logic [31:0]       r_word;
    logic [31:0]       r_rsp_data;
    logic              r_rsp_err;
    logic [7:0]        r_tmo_cnt;

    logic              w_bad;
    logic [1:0]        w_addr_lo;
    logic              w_tmo;
    logic [31:0]       w_load_data;
    logic [31:0]       w_merged;
    logic              w_unused_addr;

    // Address bits above the word index wrap and are deliberately dropped.
    assign w_unused_addr = |req_addr[31:MEM_AW+2];

`ifdef LSU_MISALIGN_TRAP_EN
    logic w_misalign;
    assign w_misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                        ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    assign w_bad      = !f3_valid(req_store, req_funct3) || w_misalign;
    assign w_addr_lo  = req_addr[1:0];
`else
    assign w_bad = !f3_valid(req_store, req_funct3);

    // Halfword codes end in 01, word codes in 10: align the low bits down.
    always_comb begin
        w_addr_lo = req_addr[1:0];
        if (req_funct3[1:0] == 2'b01)
            w_addr_lo = {req_addr[1], 1'b0};
        else if (req_funct3[1:0] == 2'b10)
            w_addr_lo = 2'b00;
    end
`endif

    assign w_tmo = (r_tmo_cnt == c_tmo_last);

    lsu_lane_align u_lane_align (
        .funct3      (r_funct3),
        .byte_off    (r_addr[1:0]),
        .load_word   (mem_rdata),
        .load_data   (w_load_data),
        .old_word    (r_word),
        .store_data  (r_wdata),
        .merged_word (w_merged)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        req_ready    = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        rsp_valid    = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (w_bad)
                        w_state_next = S_RESP;
                    else if (req_store && (req_funct3 == F3_W))
                        w_state_next = S_WR;
                    else
                        w_state_next = S_RD;
                end
            end
            S_RD: begin
                mem_req = 1'b1;
                if (mem_ack)
                    w_state_next = r_store ? S_MERGE : S_RESP;
                else if (w_tmo)
                    w_state_next = S_RESP;
            end
            S_MERGE: w_state_next = S_WR;
            S_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                if (mem_ack || w_tmo)
                    w_state_next = S_RESP;
            end
            S_RESP: begin
                rsp_valid    = 1'b1;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Counter clears whenever no request is pending, so each phase starts at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_tmo_cnt <= '0;
        else if (mem_req && !mem_ack && !w_tmo)
            r_tmo_cnt <= r_tmo_cnt + 8'd1;
        else
            r_tmo_cnt <= '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_store    <= 1'b0;
            r_funct3   <= '0;
            r_addr     <= '0;
            r_rd       <= '0;
            r_wdata    <= '0;
            r_word     <= '0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_store    <= req_store;
                        r_funct3   <= req_funct3;
                        r_addr     <= {req_addr[MEM_AW+1:2], w_addr_lo};
                        r_rd       <= req_rd;
                        r_wdata    <= req_wdata[15:0];
                        r_word     <= req_wdata;
                        r_rsp_data <= '0;
                        r_rsp_err  <= w_bad;
                    end
                end
                S_RD: begin
                    if (mem_ack) begin
                        r_word <= mem_rdata;
                        if (!r_store)
                            r_rsp_data <= w_load_data;
                    end else if (w_tmo) begin
                        r_rsp_err <= 1'b1;
                    end
                end
                S_MERGE: r_word <= w_merged;
                S_WR: begin
                    if (!mem_ack && w_tmo)
                        r_rsp_err <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Outputs are gated by the phase so idle/reset values are all zero.
    assign mem_addr  = mem_req ? r_addr[MEM_AW+1:2] : '0;
    assign mem_wdata = mem_we ? r_word : '0;
    assign rsp_data  = rsp_valid ? r_rsp_data : '0;
    assign rsp_rd    = (rsp_valid && !r_store) ? r_rd : '0;
    assign rsp_err   = rsp_valid && r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_master.sv
`default_nettype none
// ============================================================================
// Module  : tb_lsu_mem_master
// Brief   : Directed self-checking bench for lsu_mem_master with a word RAM
//           responder. Honours LSU_MISALIGN_TRAP_EN.
// Revision: 1.0 - initial release
// ============================================================================
module tb_lsu_mem_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_rd;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_rd;
    logic        mem_req, mem_we, mem_ack;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    logic [31:0] mem [0:255];
    bit          ack_en;
    int          req_cycles, wr_count;
    logic [7:0]  last_addr;
    logic [31:0] last_wdata;
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    lsu_mem_master #(.MEM_AW(8), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_rd(req_rd),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_rd(rsp_rd), .rsp_err(rsp_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    // Memory responder: acks the first cycle of each request (1-cycle ack).
    always @(negedge clk) begin
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        if (mem_req) begin
            req_cycles = req_cycles + 1;
            if (ack_en) begin
                mem_ack   = 1'b1;
                last_addr = mem_addr;
                if (mem_we) begin
                    mem[mem_addr] = mem_wdata;
                    last_wdata    = mem_wdata;
                    wr_count      = wr_count + 1;
                end else begin
                    mem_rdata = mem[mem_addr];
                end
            end
        end
    end

    task automatic do_txn(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [4:0] rd,
                          output bit got, output int lat, output logic [31:0] d,
                          output logic [4:0] rdo, output logic e);
        @(negedge clk);
        for (int w = 0; w < 5 && !req_ready; w++) @(negedge clk);
        req_cycles = 0; wr_count = 0; last_addr = 8'hxx; last_wdata = 32'hxxxx_xxxx;
        req_valid = 1'b1; req_store = st; req_funct3 = f3;
        req_addr = addr; req_wdata = wd; req_rd = rd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        got = 1'b0; lat = 0; d = '0; rdo = '0; e = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (rsp_valid) begin
                got = 1'b1; lat = i; d = rsp_data; rdo = rsp_rd; e = rsp_err;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'b0;
        req_addr = '0; req_wdata = '0; req_rd = '0; ack_en = 1'b1;
        #12;
        vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
        vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL reset_mem_req: got %b expected 0", mem_req); end
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        vectors++; if ({mem_we, mem_addr, mem_wdata, rsp_data, rsp_rd, rsp_err} !== '0) begin
            miscompares++; $display("FAIL reset_outputs: got %h expected 0", {mem_we, mem_addr, mem_wdata, rsp_data, rsp_rd, rsp_err}); end
        @(negedge clk); rst_n = 1'b1;
    endtask

    // Latency below counts clock edges after the accept edge: load/SW 1 and
    // SB/SH 3 correspond to 3 and 5 cycles counting the accept cycle.
    task automatic test_loads();
        bit g; int l; logic [31:0] d; logic [4:0] r; logic e;
        mem[1] = 32'h80FF_1234;
        do_txn(1'b0, 3'b000, 32'h0000_0007, 32'h0, 5'd5, g, l, d, r, e);
        vectors++; if (!g || l != 1) begin miscompares++; $display("FAIL lb_latency: got %0d (seen %0d) expected 1", l, g); end
        vectors++; if (d !== 32'hFFFF_FF80) begin miscompares++; $display("FAIL lb_data: got %h expected ffffff80", d); end
        vectors++; if (r !== 5'd5 || e !== 1'b0) begin miscompares++; $display("FAIL lb_rd_err: got rd %0d err %b expected rd 5 err 0", r, e); end
        vectors++; if (last_addr !== 8'd1) begin miscompares++; $display("FAIL lb_mem_addr: got %h expected 01", last_addr); end
        do_txn(1'b0, 3'b000, 32'h0000_0407, 32'h0, 5'd9, g, l, d, r, e);
        vectors++; if (last_addr !== 8'd1 || d !== 32'hFFFF_FF80) begin miscompares++; $display("FAIL lb_wrap: got addr %h data %h expected 01 ffffff80", last_addr, d); end
        do_txn(1'b0, 3'b100, 32'h0000_0006, 32'h0, 5'd1, g, l, d, r, e);
        vectors++; if (d !== 32'h0000_00FF) begin miscompares++; $display("FAIL lbu_data: got %h expected 000000ff", d); end
        do_txn(1'b0, 3'b001, 32'h0000_0006, 32'h0, 5'd2, g, l, d, r, e);
        vectors++; if (d !== 32'hFFFF_80FF) begin miscompares++; $display("FAIL lh_data: got %h expected ffff80ff", d); end
        do_txn(1'b0, 3'b010, 32'h0000_0004, 32'h0, 5'd31, g, l, d, r, e);
        vectors++; if (d !== 32'h80FF_1234 || r !== 5'd31) begin miscompares++; $display("FAIL lw_data: got %h rd %0d expected 80ff1234 rd 31", d, r); end
    endtask

    task automatic test_sub_word_store();
        bit g; int l; logic [31:0] d; logic [4:0] r; logic e;
        mem[1] = 32'h1122_3344;
        do_txn(1'b1, 3'b000, 32'h0000_0005, 32'hFFFF_FFAB, 5'd7, g, l, d, r, e);
        vectors++; if (!g || l != 3) begin miscompares++; $display("FAIL sb_latency: got %0d (seen %0d) expected 3", l, g); end
        vectors++; if (last_wdata !== 32'h1122_AB44 || wr_count != 1) begin miscompares++; $display("FAIL sb_wdata: got %h x%0d expected 1122ab44 x1", last_wdata, wr_count); end
        vectors++; if (mem[1] !== 32'h1122_AB44) begin miscompares++; $display("FAIL sb_mem: got %h expected 1122ab44", mem[1]); end
        vectors++; if (d !== 32'h0 || r !== 5'd0 || e !== 1'b0) begin miscompares++; $display("FAIL sb_rsp: got data %h rd %0d err %b expected 0 0 0", d, r, e); end
        do_txn(1'b1, 3'b001, 32'h0000_0006, 32'h1234_CAFE, 5'd0, g, l, d, r, e);
        vectors++; if (mem[1] !== 32'hCAFE_AB44 || l != 3) begin miscompares++; $display("FAIL sh_mem: got %h lat %0d expected cafeab44 lat 3", mem[1], l); end
    endtask

    task automatic test_back_to_back();
        bit g; int l; logic [31:0] d; logic [4:0] r; logic e;
        do_txn(1'b1, 3'b010, 32'h0000_0000, 32'hDEAD_BEEF, 5'd0, g, l, d, r, e);
        vectors++; if (!g || l != 1 || mem[0] !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL sw: got lat %0d mem %h expected lat 1 deadbeef", l, mem[0]); end
        do_txn(1'b0, 3'b101, 32'h0000_0002, 32'h0, 5'd10, g, l, d, r, e);
        vectors++; if (d !== 32'h0000_DEAD) begin miscompares++; $display("FAIL lhu_data: got %h expected 0000dead", d); end
        do_txn(1'b0, 3'b001, 32'h0000_0000, 32'h0, 5'd11, g, l, d, r, e);
        vectors++; if (d !== 32'hFFFF_BEEF) begin miscompares++; $display("FAIL lh_lo_data: got %h expected ffffbeef", d); end
    endtask

    task automatic test_timeout();
        bit g; int l; logic [31:0] d; logic [4:0] r; logic e;
        ack_en = 1'b0;
        mem[2] = 32'h0BAD_F00D;
        do_txn(1'b0, 3'b010, 32'h0000_0008, 32'h0, 5'd3, g, l, d, r, e);
        vectors++; if (!g || l != 16) begin miscompares++; $display("FAIL tmo_latency: got %0d (seen %0d) expected 16", l, g); end
        vectors++; if (e !== 1'b1 || d !== 32'h0) begin miscompares++; $display("FAIL tmo_rsp: got err %b data %h expected 1 0", e, d); end
        vectors++; if (req_cycles != 16 || mem_req !== 1'b0) begin miscompares++; $display("FAIL tmo_req: got %0d cycles req %b expected 16 0", req_cycles, mem_req); end
        @(posedge clk); #1;
        vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL tmo_ready: got %b expected 1", req_ready); end
        do_txn(1'b1, 3'b010, 32'h0000_0008, 32'h1234_5678, 5'd0, g, l, d, r, e);
        vectors++; if (e !== 1'b1 || mem[2] !== 32'h0BAD_F00D) begin miscompares++; $display("FAIL tmo_store: got err %b mem %h expected 1 0badf00d", e, mem[2]); end
        ack_en = 1'b1;
    endtask

    task automatic test_bad_funct3();
        bit g; int l; logic [31:0] d; logic [4:0] r; logic e;
        do_txn(1'b0, 3'b011, 32'h0000_0000, 32'h0, 5'd6, g, l, d, r, e);
        vectors++; if (!g || l != 0 || e !== 1'b1) begin miscompares++; $display("FAIL bad_ld: got lat %0d err %b expected 0 1", l, e); end
        vectors++; if (req_cycles != 0 || d !== 32'h0) begin miscompares++; $display("FAIL bad_ld_mem: got %0d req cycles data %h expected 0 0", req_cycles, d); end
        do_txn(1'b1, 3'b101, 32'h0000_0000, 32'h1, 5'd0, g, l, d, r, e);
        vectors++; if (!g || l != 0 || e !== 1'b1 || req_cycles != 0) begin miscompares++; $display("FAIL bad_st: got lat %0d err %b req %0d expected 0 1 0", l, e, req_cycles); end
    endtask

    task automatic test_misalign();
        bit g; int l; logic [31:0] d; logic [4:0] r; logic e;
        mem[0] = 32'hDEAD_BEEF;
        do_txn(1'b0, 3'b010, 32'h0000_0003, 32'h0, 5'd4, g, l, d, r, e);
`ifdef LSU_MISALIGN_TRAP_EN
        vectors++; if (e !== 1'b1 || l != 0 || req_cycles != 0) begin miscompares++; $display("FAIL lw_mis: got err %b lat %0d req %0d expected 1 0 0", e, l, req_cycles); end
`else
        vectors++; if (e !== 1'b0 || d !== 32'hDEAD_BEEF || last_addr !== 8'd0) begin miscompares++; $display("FAIL lw_mis: got err %b data %h addr %h expected 0 deadbeef 00", e, d, last_addr); end
`endif
        do_txn(1'b0, 3'b001, 32'h0000_0001, 32'h0, 5'd4, g, l, d, r, e);
`ifdef LSU_MISALIGN_TRAP_EN
        vectors++; if (e !== 1'b1 || d !== 32'h0) begin miscompares++; $display("FAIL lh_mis: got err %b data %h expected 1 0", e, d); end
`else
        vectors++; if (e !== 1'b0 || d !== 32'hFFFF_BEEF) begin miscompares++; $display("FAIL lh_mis: got err %b data %h expected 0 ffffbeef", e, d); end
`endif
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        ack_en = 1'b0;
        mem[4] = 32'h55AA_55AA;
        @(negedge clk);
        for (int w = 0; w < 5 && !req_ready; w++) @(negedge clk);
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h0000_0010; req_wdata = 32'h1234_5678; req_rd = 5'd0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk); @(negedge clk);
        vectors++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 8'd4) begin miscompares++; $display("FAIL rst_wr_phase: got req %b we %b addr %h expected 1 1 04", mem_req, mem_we, mem_addr); end
        #2 rst_n = 1'b0;
        #1;
        vectors++; if (mem_req !== 1'b0 || rsp_valid !== 1'b0) begin miscompares++; $display("FAIL rst_async: got req %b rsp %b expected 0 0", mem_req, rsp_valid); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 1) rst_n = 1'b1;
            if (rsp_valid) seen++;
        end
        vectors++; if (seen != 0 || mem[4] !== 32'h55AA_55AA) begin miscompares++; $display("FAIL rst_no_rsp: got %0d rsp mem %h expected 0 55aa55aa", seen, mem[4]); end
        vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready: got %b expected 1", req_ready); end
        ack_en = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        req_cycles = 0; wr_count = 0;
        test_reset();
        test_loads();
        test_sub_word_store();
        test_back_to_back();
        test_timeout();
        test_bad_funct3();
        test_misalign();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
